q15_integrate_dump: RTL and testbench
=====================================

# q15_integrate_dump

Integrate-and-dump stage for the receive datapath. It consumes the signed Q0.15 product stream from the 16x16 Q0.15 multiplier stage (mixer/correlator products). Each window of N accepted samples is summed in a wide accumulator, then scaled by a programmable right shift with rounding. The result is saturated back to Q0.15 and presented on a valid/ready output, feeding the downstream detection and decision logic.

## Interface
- DATAWIDTH, 16, sample and result width (signed Q0.15)
- LEN_WIDTH, 10, width of window-length input; max N = 2^LEN_WIDTH - 1
- ACC_WIDTH, 32, accumulator width; must be ≥ DATAWIDTH + LEN_WIDTH (no internal overflow possible)

Ports:
- clk_i  in  1  single clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- len_i  in  LEN_WIDTH  window length N; latched on first sample of each window; 0 treated as 1
- shift_i  in  5  right shift applied to window sum, 0..ACC_WIDTH-1; latched with len_i
- s_valid_i  in  1  input sample valid
- s_data_i  in  DATAWIDTH  signed Q0.15 sample
- s_ready_o  out  1  input ready
- m_valid_o  out  1  result valid
- m_data_o  out  DATAWIDTH  signed Q0.15 result
- m_sat_o  out  1  result was clipped during saturation
- m_ready_i  in  1  downstream ready

## Operation
- Input accept: s_valid_i & s_ready_o. Output accept: m_valid_o & m_ready_i.
- s_ready_o = ~m_valid_o | m_ready_i. This is combinational from m_ready_i; no other stall source.
- FSM states:
  - IDLE: no window open, cnt=0.
  - ACC: window open.
- Transitions:
  - IDLE → ACC on an accepted sample when N>1.
  - ACC → IDLE on acceptance of the Nth sample.
  - IDLE → IDLE when N=1 (the sample dumps immediately).
- First sample of a window (in IDLE):
  - Latch N = max(len_i,1) and shift_i.
  - acc ← sext(s_data_i); cnt ← 1.
- Subsequent accepted samples: acc ← acc + sext(s_data_i); cnt ← cnt+1.
- len_i and shift_i changes mid-window are ignored until the next window.
- On acceptance of sample N, let sum = the accumulator value including that sample:
  - If sh>0: r = (sum + 2^(sh-1)) >>> sh (round half toward +inf, arithmetic shift). If sh=0: r = sum.
  - r > 32767 → m_data_o=0x7FFF, m_sat_o=1.
  - r < -32768 → m_data_o=0x8000, m_sat_o=1.
  - Otherwise m_data_o=r[15:0], m_sat_o=0.
  - Load output register, set m_valid_o, return to IDLE, cnt ← 0.
  - Rounding add is done at ACC_WIDTH+1 bits so it cannot wrap.
- Output register:
  - m_data_o and m_sat_o hold stable while m_valid_o & ~m_ready_i.
  - m_valid_o clears on output accept unless a new result loads in the same cycle. Load wins, so m_valid_o stays 1 with new data.
- Idle cycles (s_valid_i=0) inside a window do not advance cnt; the window is open-ended in time.
- Reset mid-window discards the partial sum; no result is emitted for it.

## Timing
- Reset values:
  - m_valid_o=0, m_data_o=0, m_sat_o=0
  - acc=0, cnt=0, state IDLE
  - s_ready_o=1 after reset
- Latency: Nth sample accepted at edge t → m_valid_o=1 and result visible after edge t (cycle t+1).
- Throughput: one sample per cycle sustained when m_ready_i=1. With N=1, one result per cycle.
- Backpressure: while m_valid_o=1 and m_ready_i=0, s_ready_o=0. No sample is accepted or lost, and no partial state changes.
- Simultaneous events:
  - Output accept and Nth-sample accept in the same cycle: the new result replaces the old one; m_valid_o stays 1.
  - Reset asserted in the same cycle as any accept: reset wins.

## Test plan
- N=4, shift=2, four samples 0x1000 back-to-back, m_ready_i=1 → m_data_o=0x1000, m_sat_o=0, m_valid_o high exactly one cycle after the 4th accept.
- N=4, shift=0, four 0x7FFF → 0x7FFF, m_sat_o=1. Then four 0x8000 → 0x8000, m_sat_o=1.
- N=2, shift=1: samples 1,2 → 0x0002. Samples −1,−2 (sum −3) → 0xFFFF (−1). Confirms round-half-up.
- N=2, m_ready_i held low 5 cycles after the first result, s_valid_i=1 continuously → s_ready_o=0 for those cycles, m_data_o stable. After release, the next windows complete with no lost or duplicated samples (scoreboard vs. reference sum).
- len_i=0, samples 0x0100, 0x0200 → two results 0x0100, 0x0200 on consecutive cycles. len_i changed 4→2 after the first sample of a 4-window → that window still closes after 4 samples.
- N=4, reset pulsed after 2 accepted samples, then four 0x0010 with shift=0 → single result 0x0040. The discarded partial window produces no output.

Source files
------------

// File: rtl/q15_integrate_dump.sv
// q15_integrate_dump: windowed integrate-and-dump with rounding right shift and Q0.15 saturation
module q15_integrate_dump #(
  parameter int DATAWIDTH = 16,
  parameter int LEN_WIDTH = 10,
  parameter int ACC_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic [4:0]           shift_i,
  input  logic                 s_valid_i,
  input  logic [DATAWIDTH-1:0] s_data_i,
  output logic                 s_ready_o,
  output logic                 m_valid_o,
  output logic [DATAWIDTH-1:0] m_data_o,
  output logic                 m_sat_o,
  input  logic                 m_ready_i
);
  typedef enum logic {IDLE, ACC} state_t;
  localparam logic signed [ACC_WIDTH:0] MAX_V = (ACC_WIDTH+1)'((1 << (DATAWIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH:0] MIN_V = -MAX_V - 1;
  state_t                 r_state;
  logic [LEN_WIDTH-1:0]   r_n, r_cnt;
  logic [4:0]             r_sh;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic                   w_take, w_first, w_last, w_hi, w_lo;
  logic [LEN_WIDTH-1:0]   w_n, w_cnt;
  logic [4:0]             w_sh;
  logic [ACC_WIDTH-1:0]   w_ext, w_sum;
  logic signed [ACC_WIDTH:0] w_rnd, w_wide, w_r;
  assign s_ready_o = ~m_valid_o | m_ready_i;
  // window parameters, running sum including this sample, and the rounded/shifted/clipped result
  always_comb begin
    w_take  = s_valid_i & s_ready_o;
    w_first = r_state == IDLE;
    w_n     = w_first ? (len_i == '0 ? LEN_WIDTH'(1) : len_i) : r_n;
    w_sh    = w_first ? shift_i : r_sh;
    w_ext   = {{(ACC_WIDTH-DATAWIDTH){s_data_i[DATAWIDTH-1]}}, s_data_i};
    w_sum   = w_first ? w_ext : r_acc + w_ext;
    w_cnt   = w_first ? LEN_WIDTH'(1) : r_cnt + LEN_WIDTH'(1);
    w_last  = w_cnt == w_n;
    w_rnd   = w_sh == 5'd0 ? '0 : (ACC_WIDTH+1)'(1) << (w_sh - 5'd1);
    w_wide  = $signed({w_sum[ACC_WIDTH-1], w_sum}) + w_rnd;
    w_r     = w_wide >>> w_sh;
    w_hi    = w_r > MAX_V;
    w_lo    = w_r < MIN_V;
  end
  // window FSM with registered result; a new result load overrides the output-accept clear
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_n       <= '0;
      r_sh      <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_sat_o   <= 1'b0;
    end else begin
      if (m_valid_o & m_ready_i) m_valid_o <= 1'b0;
      if (w_take) begin
        r_n  <= w_n;
        r_sh <= w_sh;
        if (w_last) begin
          r_state   <= IDLE;
          r_cnt     <= '0;
          r_acc     <= '0;
          m_valid_o <= 1'b1;
          m_sat_o   <= w_hi | w_lo;
          m_data_o  <= w_hi ? {1'b0, {(DATAWIDTH-1){1'b1}}} : w_lo ? {1'b1, {(DATAWIDTH-1){1'b0}}} : w_r[DATAWIDTH-1:0];
        end else begin
          r_state <= ACC;
          r_cnt   <= w_cnt;
          r_acc   <= w_sum;
        end
      end
    end
  end
endmodule

// File: tb/tb_q15_integrate_dump.sv
// tb_q15_integrate_dump: directed literal checks plus randomized traffic against a behavioural model
module tb_q15_integrate_dump;
  logic        clk_i = 0, rst_i = 1;
  logic [9:0]  len_i = 10'd4;
  logic [4:0]  shift_i = 5'd0;
  logic        s_valid_i = 0;
  logic [15:0] s_data_i = 0;
  logic        m_ready_i = 1;
  logic        s_ready_o, m_valid_o, m_sat_o;
  logic [15:0] m_data_o;
  int checks = 0, errors = 0;
  bit chk_en = 0, rand_rdy = 0, fix_rdy = 1;
  bit exp_v = 0, exp_s = 0, open_w = 0;
  logic [15:0] exp_d = 0;
  int n_m = 0, sh_m = 0, cnt_m = 0;
  longint sum_m = 0;

  q15_integrate_dump dut (
    .clk_i(clk_i), .rst_i(rst_i), .len_i(len_i), .shift_i(shift_i),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
    .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_sat_o(m_sat_o), .m_ready_i(m_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: collect each window's samples, sum them, round-shift and clip with plain integer math
  always @(posedge clk_i) begin
    if (rst_i) begin
      exp_v = 0; exp_d = 0; exp_s = 0; open_w = 0;
    end else begin
      bit take;
      longint r;
      take = s_valid_i && (!exp_v || m_ready_i);
      if (exp_v && m_ready_i) exp_v = 0;
      if (take) begin
        if (!open_w) begin
          n_m = len_i == 0 ? 1 : int'(len_i);
          sh_m = int'(shift_i);
          sum_m = 0; cnt_m = 0; open_w = 1;
        end
        sum_m += longint'($signed(s_data_i));
        cnt_m++;
        if (cnt_m == n_m) begin
          r = sh_m == 0 ? sum_m : (sum_m + (longint'(1) <<< (sh_m - 1))) >>> sh_m;
          exp_s = r > 32767 || r < -32768;
          exp_d = r > 32767 ? 16'h7fff : r < -32768 ? 16'h8000 : r[15:0];
          exp_v = 1; open_w = 0;
        end
      end
    end
  end

  always @(negedge clk_i) if (chk_en) begin
    chk("m_valid", m_valid_o, exp_v);
    chk("s_ready", s_ready_o, !exp_v || m_ready_i);
    if (exp_v) begin
      chk("m_data", m_data_o, exp_d);
      chk("m_sat", m_sat_o, exp_s);
    end
  end

  always @(negedge clk_i) begin
    #1;
    m_ready_i = rand_rdy ? ($urandom_range(0, 3) != 0) : fix_rdy;
  end

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk_i); #2; end
  endtask

  task automatic push(input logic [15:0] d);
    bit got = 0;
    s_valid_i = 1;
    s_data_i = d;
    for (int k = 0; k < 300 && !got; k++) begin
      #1;
      got = s_ready_o;
      @(negedge clk_i); #2;
    end
    if (!got) chk("push_timeout", 0, 1);
    s_valid_i = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end, got running expected finished");
    $fatal(1);
  end

  initial begin
    idle(2);
    chk_en = 1;
    chk("rst_valid", m_valid_o, 0);
    chk("rst_data", m_data_o, 0);
    chk("rst_sat", m_sat_o, 0);
    chk("rst_ready", s_ready_o, 1);
    rst_i = 0;
    idle(1);
    len_i = 4; shift_i = 2;
    repeat (3) push(16'h1000);
    chk("t1_early", m_valid_o, 0);
    push(16'h1000);
    chk("t1_valid", m_valid_o, 1);
    chk("t1_data", m_data_o, 16'h1000);
    chk("t1_sat", m_sat_o, 0);
    idle(1);
    chk("t1_one_cycle", m_valid_o, 0);
    shift_i = 0;
    repeat (4) push(16'h7fff);
    chk("sat_hi_data", m_data_o, 16'h7fff);
    chk("sat_hi_flag", m_sat_o, 1);
    repeat (4) push(16'h8000);
    chk("sat_lo_data", m_data_o, 16'h8000);
    chk("sat_lo_flag", m_sat_o, 1);
    len_i = 2; shift_i = 1;
    push(16'h0001); push(16'h0002);
    chk("rnd_pos", m_data_o, 16'h0002);
    push(16'hffff); push(16'hfffe);
    chk("rnd_neg", m_data_o, 16'hffff);
    chk("rnd_neg_sat", m_sat_o, 0);
    shift_i = 0;
    push(16'h0010);
    fix_rdy = 0;
    push(16'h0020);
    chk("bp_first", m_data_o, 16'h0030);
    fork
      push(16'h0040);
      begin
        repeat (5) begin
          @(negedge clk_i); #2;
          chk("bp_ready", s_ready_o, 0);
          chk("bp_hold", m_data_o, 16'h0030);
        end
        fix_rdy = 1;
      end
    join
    push(16'h0050);
    chk("bp_next", m_data_o, 16'h0090);
    len_i = 0;
    push(16'h0100);
    chk("n1_a", m_data_o, 16'h0100);
    push(16'h0200);
    chk("n1_b_valid", m_valid_o, 1);
    chk("n1_b", m_data_o, 16'h0200);
    len_i = 4; shift_i = 2;
    push(16'h0100);
    len_i = 2;
    push(16'h0100);
    chk("len_chg_open", m_valid_o, 0);
    push(16'h0100);
    chk("len_chg_open2", m_valid_o, 0);
    push(16'h0100);
    chk("len_chg_data", m_data_o, 16'h0100);
    len_i = 4; shift_i = 0;
    push(16'h1234); push(16'h1234);
    rst_i = 1;
    idle(1);
    rst_i = 0;
    repeat (3) push(16'h0010);
    chk("rst_discard", m_valid_o, 0);
    push(16'h0010);
    chk("rst_data_after", m_data_o, 16'h0040);
    rand_rdy = 1;
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      len_i = 10'($urandom_range(0, 6));
      shift_i = $urandom_range(0, 3) == 0 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
      case ($urandom_range(0, 3))
        0: push(16'h7fff);
        1: push(16'h8000);
        default: push(16'($urandom));
      endcase
    end
    len_i = 10'd1023; shift_i = 5'd10;
    repeat (1030) push($urandom_range(0, 1) == 0 ? 16'h8000 : 16'h7fff);
    rand_rdy = 0;
    fix_rdy = 1;
    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
